pause_ce_gate: RTL and testbench
================================

# pause_ce_gate

Consumer side of the core pause signal: takes the active-high `pause_cpu` request and turns it into a gated CPU clock-enable that stops only at a safe bus boundary. It returns a `pause_ack` handshake so the hiscore, save-state and DMA logic know the CPU is actually frozen. It sits between the pause controller and the CPU core's `ce` input. A bounded drain timeout guarantees that a pause always lands.

## Interface
- `CE_DIV`, 4: clk_sys cycles per CPU clock-enable pulse; must be ≥1.
- `TIMEOUT`, 1024: maximum clk_sys cycles spent waiting for `bus_idle` before forcing the stop; must be ≥1.

- `clk_sys` input 1: core system clock; single clock domain.
- `reset_n` input 1: asynchronous, active-low reset.
- `pause_cpu` input 1: pause request from the pause controller, active-high, level.
- `bus_idle` input 1: CPU reports a safe stop point (no bus cycle in flight); sampled at the CE terminal count.
- `ce_cpu` output 1: CPU clock-enable, one-cycle pulse, registered.
- `pause_ack` output 1: high while the CPU is frozen, registered.
- `forced` output 1: the current pause was entered by timeout, not at a clean boundary.
- `resume_pulse` output 1: single-cycle strobe on leaving the paused state.

## Operation
- `div_cnt` counts 0..CE_DIV-1 and wraps. A terminal count (`tc`) occurs when `div_cnt == CE_DIV-1`.
- `drain_cnt` counts clk_sys cycles spent in DRAIN.
- FSM states:
  - **RUN**
    - `ce_cpu` pulses on every `tc`.
    - `pause_cpu=1` moves to DRAIN on the next edge.
  - **DRAIN**
    - `ce_cpu` keeps pulsing and `drain_cnt` increments each cycle.
    - On a `tc` cycle with `bus_idle=1`: suppress that `ce_cpu` pulse and go to PAUSED with `forced=0`.
    - When `drain_cnt == TIMEOUT-1`: go to PAUSED with `forced=1`, with no `ce_cpu` that cycle.
    - `pause_cpu=0`: go back to RUN and clear `drain_cnt`.
  - **PAUSED**
    - `ce_cpu=0`, `pause_ack=1`, `div_cnt` held at 0.
    - `pause_cpu=0` moves to RESUME.
  - **RESUME**
    - One cycle only: `pause_ack=0`, `resume_pulse=1`, `forced` cleared, `div_cnt` restarts from 0.
    - Always goes to RUN next.
- Simultaneous events and limits:
  - In DRAIN, `pause_cpu=0` beats both the idle stop and the timeout. The `tc` pulse fires normally and the state returns to RUN.
  - On a `tc` cycle that is also the timeout cycle with `bus_idle=1`, the stop counts as clean (`forced=0`).
  - CE_DIV=1: `tc` is true every cycle, so stop and resume behaviour is unchanged.
  - `pause_cpu` re-asserted during RESUME is ignored that cycle and seen in RUN on the following cycle.
- Widths:
  - `div_cnt` is max(1, $clog2(CE_DIV)) bits.
  - `drain_cnt` is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

## Timing
- Reset (`reset_n=0`, asynchronous):
  - State goes to RUN; `div_cnt` and `drain_cnt` clear to 0.
  - `ce_cpu`, `pause_ack`, `forced` and `resume_pulse` all reset to 0.
- After reset release, the first `ce_cpu` is on the CE_DIV-th rising edge of `clk_sys`. After that the period is exactly CE_DIV cycles.
- Latency from `pause_cpu` rising to `pause_ack`:
  - Minimum 2 cycles: one to enter DRAIN, then a clean `tc` stop.
  - Maximum TIMEOUT+1 cycles.
- From `pause_cpu` falling in PAUSED:
  - `pause_ack` drops 1 cycle later and `resume_pulse` is high in that same cycle.
  - The first post-resume `ce_cpu` comes CE_DIV cycles after RESUME.
- Reset asserted mid-DRAIN or mid-PAUSED takes effect immediately. No acknowledge is produced.
- `pause_ack` and `ce_cpu` are never high in the same cycle.

## Structure
- Shared header `pause_pkg.vh` holds:
  - the state encodings `PS_RUN`, `PS_DRAIN`, `PS_PAUSED`, `PS_RESUME` (2-bit);
  - the default CE_DIV and TIMEOUT constants, reused by the pause controller.
- One sub-module, `ce_div`: a parameterised divider with synchronous `hold` and `clear` inputs, a `tc` output, and the same active-low async reset.
- The FSM, the drain counter and the output registers stay in the top level.

## Test plan
- Reset release, no pause, CE_DIV=4 → `ce_cpu` high on cycles 4, 8, 12, …; `pause_ack=0` throughout.
- `bus_idle` held at 1, `pause_cpu` raised on cycle 10 → DRAIN, then the next `tc` pulse is suppressed, `pause_ack=1` and `forced=0`; no further `ce_cpu`.
- `bus_idle` held at 0, TIMEOUT=16 → `pause_ack=1` and `forced=1` exactly 17 cycles after `pause_cpu` rises.
- Release `pause_cpu` while paused → `resume_pulse` for exactly 1 cycle together with `pause_ack=0` and `forced=0`; the next `ce_cpu` comes 4 cycles later.
- `pause_cpu` dropped on a `tc` cycle during DRAIN with `bus_idle=1` → `ce_cpu` fires, state returns to RUN, no `pause_ack`.
- `reset_n` pulsed low for 1 cycle while paused → all outputs 0 immediately; the first `ce_cpu` comes 4 cycles after release.

Source files
------------

// File: rtl/pause_ce_gate_pkg.sv
// Shared definitions for the pause path: FSM state encodings and the
// default divider/timeout constants also used by the pause controller.
package pause_ce_gate_pkg;

    typedef enum logic [1:0] {
        PS_RUN    = 2'd0,
        PS_DRAIN  = 2'd1,
        PS_PAUSED = 2'd2,
        PS_RESUME = 2'd3
    } pause_state_e;

    localparam int CE_DIV_DEFAULT  = 4;
    localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/ce_div.sv
// Clock-enable divider: counts 0..DIV-1, flags the terminal count, and can be
// frozen (hold) or zeroed (clear) synchronously.
module ce_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_hold,
    input  logic i_clear,
    output logic o_tc
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    // Divider counter; clear has priority over hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (i_clear) begin
            r_cnt <= {W{1'b0}};
        end else if (i_hold) begin
            r_cnt <= r_cnt;
        end else if (r_cnt == LAST) begin
            r_cnt <= {W{1'b0}};
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/pause_ce_gate.sv
// Gates the CPU clock-enable so a pause request lands on a safe bus boundary,
// with a bounded drain timeout and a registered acknowledge handshake.
module pause_ce_gate
    import pause_ce_gate_pkg::*;
#(
    parameter int CE_DIV  = CE_DIV_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pause_cpu,
    input  logic bus_idle,
    output logic ce_cpu,
    output logic pause_ack,
    output logic forced,
    output logic resume_pulse
);

    localparam int DCW = $clog2(TIMEOUT + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(TIMEOUT - 1);
    localparam logic [DCW-1:0] DRAIN_MAX  = {DCW{1'b1}};

    pause_state_e   r_state;
    pause_state_e   w_next;
    logic [DCW-1:0] r_drain_cnt;
    logic           r_ce;
    logic           r_ack;
    logic           r_forced;
    logic           r_resume;
    logic           w_tc;
    logic           w_ce;
    logic           w_forced_stop;
    logic           w_timeout;
    logic           w_div_hold;
    logic           w_div_clear;

    // Divider is zeroed on the way into PAUSED and frozen there, so RESUME starts at 0.
    assign w_div_hold  = (r_state == PS_PAUSED);
    assign w_div_clear = (r_state != PS_PAUSED) && (w_next == PS_PAUSED);
    assign w_timeout   = (r_drain_cnt == DRAIN_LAST);

    ce_div #(
        .DIV (CE_DIV)
    ) u_ce_div (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_hold  (w_div_hold),
        .i_clear (w_div_clear),
        .o_tc    (w_tc)
    );

    // Next-state and clock-enable decision; a released request beats both stop causes.
    always_comb begin
        w_next        = r_state;
        w_ce          = 1'b0;
        w_forced_stop = 1'b0;
        case (r_state)
            PS_RUN: begin
                w_ce = w_tc;
                if (pause_cpu) begin
                    w_next = PS_DRAIN;
                end else begin
                    w_next = PS_RUN;
                end
            end
            PS_DRAIN: begin
                if (!pause_cpu) begin
                    w_next = PS_RUN;
                    w_ce   = w_tc;
                end else if (w_tc && bus_idle) begin
                    w_next = PS_PAUSED;
                end else if (w_timeout) begin
                    w_next        = PS_PAUSED;
                    w_forced_stop = 1'b1;
                end else begin
                    w_next = PS_DRAIN;
                    w_ce   = w_tc;
                end
            end
            PS_PAUSED: begin
                if (!pause_cpu) begin
                    w_next = PS_RESUME;
                end else begin
                    w_next = PS_PAUSED;
                end
            end
            PS_RESUME: begin
                w_next = PS_RUN;
                w_ce   = w_tc;
            end
            default: begin
                w_next = PS_RUN;
            end
        endcase
    end

    // State, drain counter and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= PS_RUN;
            r_drain_cnt <= {DCW{1'b0}};
            r_ce        <= 1'b0;
            r_ack       <= 1'b0;
            r_forced    <= 1'b0;
            r_resume    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ce     <= w_ce;
            r_ack    <= (w_next == PS_PAUSED);
            r_resume <= (w_next == PS_RESUME);
            if ((r_state == PS_DRAIN) && (w_next == PS_DRAIN)) begin
                r_drain_cnt <= (r_drain_cnt == DRAIN_MAX) ? r_drain_cnt : r_drain_cnt + DCW'(1);
            end else begin
                r_drain_cnt <= {DCW{1'b0}};
            end
            if (w_next != PS_PAUSED) begin
                r_forced <= 1'b0;
            end else if (r_state == PS_PAUSED) begin
                r_forced <= r_forced;
            end else begin
                r_forced <= w_forced_stop;
            end
        end
    end

    assign ce_cpu       = r_ce;
    assign pause_ack    = r_ack;
    assign forced       = r_forced;
    assign resume_pulse = r_resume;

endmodule

// File: tb/tb_pause_ce_gate.sv
// Randomized and directed bench for pause_ce_gate against a cycle-time model.
module tb_pause_ce_gate;

    localparam int CE_DIV  = 4;
    localparam int TIMEOUT = 16;
    localparam int M_RUN = 0, M_DRAIN = 1, M_PAUSED = 2, M_RESUME = 3;

    logic clk_sys   = 1'b0;
    logic reset_n   = 1'b0;
    logic pause_cpu = 1'b0;
    logic bus_idle  = 1'b0;
    logic ce_cpu, pause_ack, forced, resume_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // model: absolute cycle index, phase origin of the CE grid, drain start cycle
    int   m_cyc = 0, m_origin = 0, m_dstart = 0, m_mode = M_RUN;
    logic e_ce = 1'b0, e_ack = 1'b0, e_forced = 1'b0, e_res = 1'b0;

    pause_ce_gate #(.CE_DIV(CE_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .pause_cpu    (pause_cpu),
        .bus_idle     (bus_idle),
        .ce_cpu       (ce_cpu),
        .pause_ack    (pause_ack),
        .forced       (forced),
        .resume_pulse (resume_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_origin = 0; m_dstart = 0; m_mode = M_RUN;
        e_ce = 1'b0; e_ack = 1'b0; e_forced = 1'b0; e_res = 1'b0;
    endtask

    // one clock edge of the reference: tc derived from elapsed cycles since origin
    task automatic model_step();
        bit tc;
        tc = ((m_cyc - m_origin) % CE_DIV) == (CE_DIV - 1);
        e_ce = 1'b0;
        e_res = 1'b0;
        case (m_mode)
            M_RUN: begin
                e_ce = tc;
                if (pause_cpu) begin m_mode = M_DRAIN; m_dstart = m_cyc + 1; end
            end
            M_DRAIN: begin
                if (!pause_cpu) begin e_ce = tc; m_mode = M_RUN; end
                else if (tc && bus_idle) begin m_mode = M_PAUSED; e_forced = 1'b0; end
                else if ((m_cyc - m_dstart) == TIMEOUT - 1) begin m_mode = M_PAUSED; e_forced = 1'b1; end
                else e_ce = tc;
            end
            M_PAUSED: begin
                if (!pause_cpu) begin
                    m_mode = M_RESUME; m_origin = m_cyc + 1; e_forced = 1'b0; e_res = 1'b1;
                end
            end
            default: begin e_ce = tc; m_mode = M_RUN; end
        endcase
        e_ack = (m_mode == M_PAUSED);
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk_sys or negedge reset_n);
        if (!reset_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk_sys);
        chk("ce_cpu", ce_cpu, e_ce);
        chk("pause_ack", pause_ack, e_ack);
        chk("forced", forced, e_forced);
        chk("resume_pulse", resume_pulse, e_res);
        chk("ack_ce_exclusive", pause_ack & ce_cpu, 1'b0);
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (pause_ack) begin n = i; break; end
        end
    endtask

    // one-cycle reset pulse issued mid low phase; returns just before edge 1
    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ce", ce_cpu, 1'b0);
        chk("rst_ack", pause_ack, 1'b0);
        chk("rst_forced", forced, 1'b0);
        chk("rst_resume", resume_pulse, 1'b0);
        @(negedge clk_sys);
        pause_cpu = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int lat;
        int idle_bias;
        repeat (3) tick();
        chk("reset_ce", ce_cpu, 1'b0);
        chk("reset_ack", pause_ack, 1'b0);
        #2 reset_n = 1'b1;

        // free run: ce on edges 4, 8, 12
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("run_ce_grid", ce_cpu, (k % 4) == 0);
            chk("run_no_ack", pause_ack, 1'b0);
        end

        // clean stop: enter DRAIN at edge 13, tc stop at edge 16
        pause_cpu = 1'b1; bus_idle = 1'b1;
        wait_ack(lat);
        chk_int("clean_latency", lat, 4);
        chk("clean_forced", forced, 1'b0);
        chk("clean_no_ce", ce_cpu, 1'b0);
        repeat (5) tick();

        // resume: pulse with ack low, next ce four cycles later
        pause_cpu = 1'b0;
        tick();
        chk("resume_pulse_hi", resume_pulse, 1'b1);
        chk("resume_ack_lo", pause_ack, 1'b0);
        chk("resume_forced_lo", forced, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("resume_ce_grid", ce_cpu, k == 4);
            if (k == 1) chk("resume_single", resume_pulse, 1'b0);
        end

        // release on the tc cycle in DRAIN: ce fires, no ack
        pause_cpu = 1'b1; bus_idle = 1'b1;
        repeat (3) tick();
        pause_cpu = 1'b0;
        tick();
        chk("drop_tc_ce", ce_cpu, 1'b1);
        chk("drop_tc_no_ack", pause_ack, 1'b0);
        tick();
        chk("drop_tc_no_ack2", pause_ack, 1'b0);

        // forced stop by timeout
        bus_idle = 1'b0; pause_cpu = 1'b1;
        wait_ack(lat);
        chk_int("timeout_latency", lat, TIMEOUT + 1);
        chk("timeout_forced", forced, 1'b1);
        repeat (3) tick();
        chk("timeout_forced_held", forced, 1'b1);

        // reset while paused: outputs clear at once, first ce on edge 4
        reset_pulse();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("postrst_ce_grid", ce_cpu, k == 4);
            chk("postrst_no_ack", pause_ack, 1'b0);
        end

        // randomized traffic
        idle_bias = 3;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ((c % 200) == 0) idle_bias = $urandom_range(0, 4);
            if ($urandom_range(0, 15) == 0) pause_cpu = ~pause_cpu;
            bus_idle = ($urandom_range(0, 3) < idle_bias);
            if ($urandom_range(0, 599) == 0) reset_pulse();
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
